// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: row-multiplexed 8x8 LED driver with per-frame map snapshot, row blanking and 4-level PWM.
// Optional DOT_MATRIX_TEST_PATTERN_EN adds i_Test_Mode to capture a fixed checkerboard instead of the map.
module dot_matrix_scanner #(
    parameter int ROW_CYCLES     = 6250,
    parameter int BLANK_CYCLES   = 250,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [63:0] i_Map_Data,
    input  logic        i_Enable,
    input  logic [1:0]  i_Brightness,
`ifdef DOT_MATRIX_TEST_PATTERN_EN
    input  logic        i_Test_Mode,
`endif
    output logic [7:0]  o_Row,
    output logic [7:0]  o_Col,
    output logic        o_Frame_Start
);
    localparam int CW = $clog2(ROW_CYCLES);
    localparam logic [7:0] ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {S_BLANK, S_ON} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    row;
    logic [63:0]   snap;
    logic [63:0]   cap_data;
    logic [1:0]    pwm_phase;
    logic          cap;
    logic          last;

`ifdef DOT_MATRIX_TEST_PATTERN_EN
    assign cap_data = i_Test_Mode ? 64'hAA55_AA55_AA55_AA55 : i_Map_Data;
`else
    assign cap_data = i_Map_Data;
`endif
    assign pwm_phase = 2'(cnt - CW'(BLANK_CYCLES));
    assign cap       = (cnt == '0) && (row == 3'd0);
    assign last      = cnt == CW'(ROW_CYCLES - 1);

    // Outputs are registered from the current slot position, so each pin lags the counter by one clock.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state         <= S_BLANK;
            cnt           <= '0;
            row           <= 3'd0;
            snap          <= '0;
            o_Row         <= ROW_OFF;
            o_Col         <= COL_OFF;
            o_Frame_Start <= 1'b0;
        end else if (!i_Enable) begin
            state         <= S_BLANK;
            cnt           <= '0;
            row           <= 3'd0;
            o_Row         <= ROW_OFF;
            o_Col         <= COL_OFF;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Frame_Start <= cap;
            if (cap)
                snap <= cap_data;
            cnt   <= last ? '0 : cnt + 1'b1;
            row   <= last ? row + 3'd1 : row;
            state <= last ? S_BLANK : (cnt == CW'(BLANK_CYCLES - 1)) ? S_ON : state;
            o_Row <= (state == S_ON) ? ((8'd1 << row) ^ ROW_OFF) : ROW_OFF;
            o_Col <= (state == S_ON && pwm_phase <= i_Brightness) ? (snap[{row, 3'b000} +: 8] ^ COL_OFF) : COL_OFF;
        end
    end
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb_dot_matrix_scanner: random and directed stimulus against a frame-position model of the scanner.
module tb_dot_matrix_scanner;
    localparam int RC = 16;
    localparam int BC = 4;
    localparam int FRAME = 8 * RC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [63:0] map = 64'h0000_0000_0000_00C3;
    logic [1:0]  bright = 2'd3;
    logic [7:0]  o_row, o_col;
    logic        o_fs;

    int vecs = 0;
    int errs = 0;

    int          m_t;
    logic [63:0] m_snap;
    logic [7:0]  e_row, e_col;
    logic        e_fs;

    always #5 clk = ~clk;

    dot_matrix_scanner #(
        .ROW_CYCLES(RC), .BLANK_CYCLES(BC), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Map_Data(map), .i_Enable(en), .i_Brightness(bright),
        .o_Row(o_row), .o_Col(o_col), .o_Frame_Start(o_fs)
    );

    function automatic logic [7:0] exp_row(int k);
        return (k % RC >= BC) ? 8'(1 << (k / RC)) : 8'h00;
    endfunction

    function automatic logic [7:0] exp_col(int k, logic [63:0] s, logic [1:0] b);
        int off = k % RC;
        logic [63:0] sh = s >> (8 * (k / RC));
        if (off < BC || (off - BC) % 4 > int'(b))
            return 8'h00;
        return sh[7:0];
    endfunction

    // Position k within the frame (0..127) is all the model needs: slot = k/16, offset = k%16.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t <= 0; m_snap <= '0; e_row <= '0; e_col <= '0; e_fs <= 1'b0;
        end else if (!en) begin
            m_t <= 0; e_row <= '0; e_col <= '0; e_fs <= 1'b0;
        end else begin
            m_t   <= (m_t + 1) % FRAME;
            if (m_t == 0) m_snap <= map;
            e_fs  <= (m_t == 0);
            e_row <= exp_row(m_t);
            e_col <= exp_col(m_t, m_snap, bright);
        end
    end

    always @(negedge clk) begin
        vecs++;
        if (o_row !== e_row || o_col !== e_col || o_fs !== e_fs || $countones(o_row) > 1) begin
            errs++;
            $display("FAIL model t=%0d: row=%h col=%h fs=%b, want row=%h col=%h fs=%b", m_t, o_row, o_col, o_fs, e_row, e_col, e_fs);
        end
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Returns on the negedge whose outputs reflect frame position k.
    task automatic at(int k);
        int n = 0;
        while (m_t != k && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("at_timeout", 8'(k), 8'(m_t));
        @(negedge clk);
    endtask

    initial begin
        int per;
        int cnt [8];
        repeat (3) @(negedge clk);
        chk("reset_row", o_row, 8'h00);
        chk("reset_fs", {7'd0, o_fs}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("fs_clock1", {7'd0, o_fs}, 8'h01);
        repeat (3) @(negedge clk);
        chk("blank_clock4", o_row, 8'h00);
        @(negedge clk);
        chk("row0_on", o_row, 8'h01);
        chk("row0_col", o_col, 8'hC3);
        repeat (11) @(negedge clk);
        chk("row0_last", o_col, 8'hC3);
        @(negedge clk);
        chk("row1_blank", o_row, 8'h00);
        repeat (4) @(negedge clk);
        chk("row1_on", o_row, 8'h02);
        chk("row1_col", o_col, 8'h00);

        at(50);
        map = 64'hFF00_0000_0000_0000;
        at(116);
        chk("row7_old", o_col, 8'h00);
        at(0);
        chk("fs_next", {7'd0, o_fs}, 8'h01);
        at(116);
        chk("row7_sel", o_row, 8'h80);
        chk("row7_new", o_col, 8'hFF);

        bright = 2'd0;
        at(116);
        for (int i = 0; i < 8; i++) begin
            chk("pwm0", o_col, (i % 4 == 0) ? 8'hFF : 8'h00);
            @(negedge clk);
        end
        bright = 2'd2;
        at(116);
        for (int i = 0; i < 8; i++) begin
            chk("pwm2", o_col, (i % 4 == 3) ? 8'h00 : 8'hFF);
            @(negedge clk);
        end
        bright = 2'd3;

        at(0);
        per = 0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        do begin
            for (int i = 0; i < 8; i++) cnt[i] += int'(o_row[i]);
            @(negedge clk);
            per++;
        end while (!o_fs && per < 300);
        chk("frame_period", 8'(per), 8'(FRAME));
        for (int i = 0; i < 8; i++) chk("row_on_count", 8'(cnt[i]), 8'(RC - BC));

        at(85);
        en = 1'b0;
        @(negedge clk);
        chk("dis_row", o_row, 8'h00);
        chk("dis_col", o_col, 8'h00);
        en = 1'b1;
        @(negedge clk);
        chk("reen_fs", {7'd0, o_fs}, 8'h01);
        repeat (4) @(negedge clk);
        chk("reen_row0", o_row, 8'h01);

        at(100);
        chk("row6_on", o_row, 8'h40);
        #3 rst = 1'b0;
        #1 chk("async_row", o_row, 8'h00);
        chk("async_fs", {7'd0, o_fs}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_fs", {7'd0, o_fs}, 8'h01);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) map = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) bright = 2'($urandom);
            if ($urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
- Consumer end of the game-logic map interface: takes the 64-bit note map and drives the 8x8 LED dot matrix, one row at a time.
- Latches a full map snapshot at each frame boundary, so a map shift mid-frame never tears the display.
- Inserts a blanking gap between rows against ghosting; provides 4-level brightness PWM.
- Sits between the game logic map output and the board row/column pins.

Parameters:
- ROW_CYCLES, 6250, clocks per row slot, including blank (50 MHz / 8 rows ≈ 1 kHz frame rate).
- BLANK_CYCLES, 250, clocks at the start of each row slot with all LEDs off; legal range 1 .. ROW_CYCLES-4.
- ROW_ACTIVE_LOW, 1, 1 = an asserted row line is driven 0.
- COL_ACTIVE_LOW, 0, 1 = a lit column line is driven 0.

Ports:
- i_Clk  in  1  system clock, 50 MHz
- i_Rst  in  1  asynchronous reset, active-low
- i_Map_Data  in  64  note map; byte k = map[8k+7:8k] is display row k; row 0 is the bottom (judgement) row, row 7 the top; bit j of a byte is column j
- i_Enable  in  1  display enable
- i_Brightness  in  2  PWM level, 0 = dimmest, 3 = full
- o_Row  out  8  row select, one-hot when asserted; bit r = physical row r
- o_Col  out  8  column data for the selected row
- o_Frame_Start  out  1  one-cycle pulse when a new snapshot is captured

Behaviour:
- Reset values:
  - o_Row and o_Col at inactive level (all 1 if the matching *_ACTIVE_LOW=1, else all 0).
  - o_Frame_Start = 0.
  - Row index = 0, slot counter = 0, state = S_BLANK, snapshot buffer = 0.
- State machine: S_BLANK, S_ON, with a slot counter running 0..ROW_CYCLES-1.
  - S_BLANK covers counter 0..BLANK_CYCLES-1. o_Row and o_Col are inactive.
  - At counter = BLANK_CYCLES, state goes to S_ON.
  - In S_ON, o_Row asserts only bit [row index]. o_Col = buffer byte [row index], gated by PWM.
  - At counter = ROW_CYCLES-1: counter goes to 0, state to S_BLANK, row index increments and wraps 7 -> 0.
- Frame capture:
  - Happens on the first cycle of a row-0 slot (counter 0, row 0), including the first slot after reset or after enable.
  - On that cycle, buffer <= i_Map_Data and o_Frame_Start = 1.
  - The buffer is held constant for the rest of the frame; changes to i_Map_Data mid-frame are ignored.
- Latency: a map value present on the capture cycle first appears at BLANK_CYCLES clocks later (row 0, S_ON).
- PWM:
  - p = low 2 bits of (counter − BLANK_CYCLES).
  - Columns are lit when p <= i_Brightness, giving duty 1/4, 2/4, 3/4, 4/4 for levels 0..3.
  - When not lit, o_Col is inactive; o_Row stays asserted.
  - i_Brightness is sampled every cycle; a change mid-row takes effect on the next cycle.
- Enable:
  - i_Enable=0: o_Row and o_Col inactive, o_Frame_Start=0; counter, row index and state are forced to their reset values; buffer is kept.
  - On i_Enable rising, scanning restarts from row 0 with a capture on the first cycle.
- Output timing: all outputs are registered, so pin transitions are glitch-free. At most one row is asserted in any cycle.
- Reset asserted mid-frame: immediate (asynchronous) return to reset values; the capture repeats on the first clock after release.

Optional Feature:
- Macro: DOT_MATRIX_TEST_PATTERN_EN.
- When defined:
  - Adds input i_Test_Mode (1 bit).
  - When i_Test_Mode=1 at a capture cycle, the buffer loads 64'hAA55_AA55_AA55_AA55 (checkerboard) instead of i_Map_Data.
  - When i_Test_Mode=0, capture is normal.
- When undefined: the port is absent and capture always uses i_Map_Data.

Test Plan (sim parameters ROW_CYCLES=16, BLANK_CYCLES=4, both ACTIVE_LOW=0, i_Brightness=3):
- Reset release with i_Enable=1, i_Map_Data=64'h0000_0000_0000_00C3 -> o_Frame_Start pulses at clock 1. Outputs are 0 for 4 clocks. Then o_Row=8'h01 and o_Col=8'hC3 for 12 clocks, then 4 blank clocks, then o_Row=8'h02 and o_Col=8'h00.
- Map changed to 64'hFF00...00 during row 3 -> rows 4..7 still show old bytes (0x00). The new top row 0xFF appears only after the next o_Frame_Start, at o_Row=8'h80.
- i_Brightness=0 in S_ON of a row with byte 0xFF -> o_Col pattern FF,00,00,00 repeating. i_Brightness=2 -> FF,FF,FF,00 repeating.
- Full frame scan -> o_Frame_Start period exactly 128 clocks. Each o_Row bit is asserted exactly 12 clocks per frame. o_Row is never multi-hot, and never asserted during a blank.
- i_Enable dropped mid row 5 -> next clock o_Row=0, o_Col=0. Re-enable -> o_Frame_Start pulses on the first enabled clock and the scan restarts at row 0.
- Reset asserted asynchronously during S_ON of row 6 -> outputs inactive without waiting for a clock edge. After release, capture and scan restart from row 0.
